// File: rtl/lsu_data_memory.sv
// ---------------------------------------------------------------------------
// lsu_data_memory
//
// Byte-addressable RV64 data memory behind the execute stage's load/store
// logic. Handles byte/half/word/double accesses with sign or zero extension
// on loads. Requests and responses use a valid/ready handshake, and the load
// latency is set by a parameter.
//
// Optional feature macro: DMEM_ERR_CHECK_EN
//   defined   : misaligned or out-of-range accesses raise resp_err. The store
//               is suppressed and the load data is 0.
//   undefined : resp_err is always 0. The address wraps modulo the depth, and
//               a misaligned lane is aligned down to the access size.
//
// Parameters
//   DEPTH_WORDS  number of 64-bit words (power of 2, >= 2)
//   READ_LATENCY cycles from load acceptance to response (1..4)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   req_valid     request present
//   req_ready     block can accept a request this cycle (depends on state only)
//   req_write     1 = store, 0 = load
//   req_size      00 byte, 01 half, 10 word, 11 double
//   req_unsigned  zero-extend the load result
//   req_addr      byte address
//   req_wdata     store data, taken from the low-order bytes
//   resp_valid    one-cycle response pulse
//   resp_rdata    load result (0 for stores and faulted accesses)
//   resp_err      access faulted, qualified by resp_valid
// ---------------------------------------------------------------------------
module lsu_data_memory #(
    parameter int DEPTH_WORDS  = 1024,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        accept;
    logic [1:0]  cnt_load;

    // Storage has no reset; its contents survive rst_n.
    logic [63:0] mem [DEPTH_WORDS];

    // ---------------- request decode (acceptance cycle) ----------------
    logic [AW-1:0] word_idx;
    logic [2:0]    lane_raw;
    logic [2:0]    size_mask;
    logic [2:0]    lane;
    logic [5:0]    shamt;
    logic [7:0]    be_base;
    logic [7:0]    be;
    logic [63:0]   wdata_sh;
    logic          misaligned;
    logic          range_err;
    logic          acc_err;
    logic [63:0]   rword;
    logic [63:0]   rshift;
    logic          sign_bit;
    logic [63:0]   load_ext;
    logic [63:0]   resp_data_p0;

    assign req_ready  = (state == S_IDLE) || (state == S_RESP);
    assign resp_valid = (state == S_RESP);
    assign accept     = req_valid && req_ready;

    assign word_idx = req_addr[AW+2:3];
    assign lane_raw = req_addr[2:0];

    always_comb begin
        size_mask = 3'b000;
        be_base   = 8'h01;
        case (req_size)
            2'b00: begin size_mask = 3'b000; be_base = 8'h01; end
            2'b01: begin size_mask = 3'b001; be_base = 8'h03; end
            2'b10: begin size_mask = 3'b011; be_base = 8'h0F; end
            default: begin size_mask = 3'b111; be_base = 8'hFF; end
        endcase
    end

    assign misaligned = |(lane_raw & size_mask);
    assign range_err  = |req_addr[63:AW+3];
    // Aligning the lane down keeps every access inside one 64-bit word.
    assign lane       = lane_raw & ~size_mask;
    assign shamt      = {lane, 3'b000};
    assign be         = be_base << lane;
    assign wdata_sh   = req_wdata << shamt;

`ifdef DMEM_ERR_CHECK_EN
    assign acc_err = misaligned | range_err;
`else
    logic unused_chk;
    assign acc_err    = 1'b0;
    assign unused_chk = misaligned ^ range_err;
`endif

    assign rword    = mem[word_idx];
    assign rshift   = rword >> shamt;

    always_comb begin
        sign_bit = 1'b0;
        load_ext = rshift;
        case (req_size)
            2'b00: begin
                sign_bit = rshift[7] & ~req_unsigned;
                load_ext = {{56{sign_bit}}, rshift[7:0]};
            end
            2'b01: begin
                sign_bit = rshift[15] & ~req_unsigned;
                load_ext = {{48{sign_bit}}, rshift[15:0]};
            end
            2'b10: begin
                sign_bit = rshift[31] & ~req_unsigned;
                load_ext = {{32{sign_bit}}, rshift[31:0]};
            end
            default: begin
                sign_bit = 1'b0;
                load_ext = rshift;
            end
        endcase
    end

    // Stores and faulted accesses report zero data.
    assign resp_data_p0 = (req_write || acc_err) ? 64'd0 : load_ext;

    // Stores respond immediately; loads count down READ_LATENCY-1 cycles.
    assign cnt_load = req_write ? 2'd0 : 2'(READ_LATENCY - 1);

    // ---------------- storage write (accepting edge) ----------------
    always_ff @(posedge clk) begin
        if (accept && req_write && !acc_err) begin
            for (int b = 0; b < 8; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_sh[8*b +: 8];
                end
            end
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = S_IDLE;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE, S_RESP: begin
                if (accept) begin
                    cnt_nxt   = cnt_load;
                    state_nxt = (cnt_load == 2'd0) ? S_RESP : S_WAIT;
                end else begin
                    cnt_nxt   = 2'd0;
                    state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                cnt_nxt   = cnt - 2'd1;
                state_nxt = (cnt == 2'd1) ? S_RESP : S_WAIT;
            end
            default: begin
                cnt_nxt   = 2'd0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ---------------- in-flight load result (captured at acceptance) ----------------
    logic [63:0] rdata_p1;
    logic        err_p1;

    always_ff @(posedge clk) begin
        if (accept) begin
            rdata_p1 <= resp_data_p0;
            err_p1   <= acc_err;
        end
    end

    // ---------------- state and response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= 2'd0;
            resp_rdata <= 64'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept && (cnt_load == 2'd0)) begin
                resp_rdata <= resp_data_p0;
                resp_err   <= acc_err;
            end else if ((state == S_WAIT) && (cnt == 2'd1)) begin
                resp_rdata <= rdata_p1;
                resp_err   <= err_p1;
            end
        end
    end

endmodule
